// File: rtl/dmem_mmio_bridge.sv
// Data-memory / MMIO bridge: passes low addresses to dmem and decodes an output FIFO,
// FIFO status word and free-running cycle counter at the top of the address space.
// Optional sticky overflow flag in STAT bit2 when MMIO_OVF_FLAG_EN is defined.
module dmem_mmio_bridge #(
    parameter logic [11:0] MMIO_BASE  = 12'hF00,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] cpu_address,
    input  logic [31:0] cpu_data,
    input  logic        cpu_wren,
    output logic [31:0] cpu_q,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int              PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(FIFO_DEPTH);
    localparam logic [11:0]     ADDR_OUT  = MMIO_BASE;
    localparam logic [11:0]     ADDR_STAT = MMIO_BASE + 12'd1;
    localparam logic [11:0]     ADDR_CNT  = MMIO_BASE + 12'd2;

    logic             w_is_dmem;
    logic             w_sel_out;
    logic             w_sel_stat;
    logic             w_sel_cnt;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push_ok;
    logic             w_ovf;
    logic [31:0]      w_stat;
    logic [31:0]      w_rdata;

    logic [31:0]      r_storage [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_level;
    logic [31:0]      r_cnt;
    logic             r_sel_q;
    logic [31:0]      r_rdata_q;

    assign w_is_dmem  = (cpu_address < MMIO_BASE);
    assign w_sel_out  = (cpu_address == ADDR_OUT);
    assign w_sel_stat = (cpu_address == ADDR_STAT);
    assign w_sel_cnt  = (cpu_address == ADDR_CNT);

    assign mem_address = cpu_address;
    assign mem_data    = cpu_data;
    assign mem_wren    = cpu_wren & w_is_dmem;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == DEPTH_LVL);
    assign w_pop      = ~w_empty & out_ready;
    assign w_push_req = cpu_wren & w_sel_out;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push_ok  = w_push_req & ((r_level < DEPTH_LVL) | w_pop);

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? 32'h0 : r_storage[r_rd_ptr];

`ifdef MMIO_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_push_req & ~w_push_ok) begin
            r_ovf <= 1'b1;
        end else if (cpu_wren & w_sel_stat) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_ovf = r_ovf;
`else
    assign w_ovf = 1'b0;
`endif

    assign w_stat = {16'h0, 8'(r_level), 5'h0, w_ovf, w_full, w_empty};

    always_comb begin
        w_rdata = 32'h0;
        if (w_sel_stat) begin
            w_rdata = w_stat;
        end else if (w_sel_cnt) begin
            w_rdata = r_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_storage[r_wr_ptr] <= cpu_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 32'h0;
        end else if (cpu_wren & w_sel_cnt) begin
            r_cnt <= cpu_data;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // MMIO loads are registered so they line up with the dmem syncram latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel_q   <= 1'b0;
            r_rdata_q <= 32'h0;
        end else begin
            r_sel_q   <= ~w_is_dmem;
            r_rdata_q <= w_rdata;
        end
    end

    assign cpu_q = r_sel_q ? r_rdata_q : mem_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Bench for dmem_mmio_bridge: directed steps plus a randomized phase, checked against
// a queue-based behavioural model of the memory map.
module tb_dmem_mmio_bridge;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic [11:0] cpu_address;
    logic [31:0] cpu_data;
    logic        cpu_wren;
    logic [31:0] cpu_q;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    dmem_mmio_bridge #(
        .MMIO_BASE (12'hF00),
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_address(cpu_address),
        .cpu_data   (cpu_data),
        .cpu_wren   (cpu_wren),
        .cpu_q      (cpu_q),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // dmem syncram stand-in: read-before-write, one-cycle read latency
    logic [31:0] env_mem [4096];
    always @(posedge clock) begin
        if (mem_wren) env_mem[mem_address] <= mem_data;
        mem_q <= env_mem[mem_address];
    end

    // Reference model state
    logic [31:0] m_q [$];
    logic [31:0] m_mem [4096];
    logic [31:0] m_cnt;
    logic        m_ovf;

    int n_cmp;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_stat();
        logic e, f, o;
        e = (m_q.size() == 0);
        f = (m_q.size() == DEPTH);
`ifdef MMIO_OVF_FLAG_EN
        o = m_ovf;
`else
        o = 1'b0;
`endif
        return {16'h0, 8'(m_q.size()), 5'h0, o, f, e};
    endfunction

    // One bus cycle: drive at negedge, check combinational outputs, advance model, check load
    task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w, input logic rdy);
        logic [31:0] exp_q;
        logic        push, pop;
        @(negedge clock);
        cpu_address = a;
        cpu_data    = d;
        cpu_wren    = w;
        out_ready   = rdy;
        #1;
        check("mem_wren", {31'h0, mem_wren}, {31'h0, w & (a < 12'hF00)});
        check("mem_address", {20'h0, mem_address}, {20'h0, a});
        check("mem_data", mem_data, d);
        check("out_valid", {31'h0, out_valid}, {31'h0, m_q.size() != 0});
        check("out_data", out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);

        if (a < 12'hF00)       exp_q = m_mem[a];
        else if (a == 12'hF01) exp_q = m_stat();
        else if (a == 12'hF02) exp_q = m_cnt;
        else                   exp_q = 32'h0;

        pop  = (m_q.size() != 0) && rdy;
        push = w && (a == 12'hF00);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end else if (w && a == 12'hF01) begin
            m_ovf = 1'b0;
        end
        if (w && a < 12'hF00) m_mem[a] = d;
        m_cnt = (w && a == 12'hF02) ? d : m_cnt + 32'd1;

        @(posedge clock);
        #1;
        check("cpu_q", cpu_q, exp_q);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt = 32'h0;
        m_ovf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] a;
        logic [31:0] d;
        int          sel;
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 4096; i++) begin
            env_mem[i] = 32'h0;
            m_mem[i]   = 32'h0;
        end
        model_reset();
        reset       = 1'b1;
        cpu_address = 12'h000;
        cpu_data    = 32'h0;
        cpu_wren    = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_cpu_q", cpu_q, 32'h0);
        reset = 1'b0;

        step(12'hF01, 32'h0, 1'b0, 1'b0);

        // dmem path
        step(12'h010, 32'hDEADBEEF, 1'b1, 1'b0);
        step(12'h010, 32'h0, 1'b0, 1'b0);
        check("dmem_load", cpu_q, 32'hDEADBEEF);

        // MMIO isolation and single push
        step(12'hF00, 32'h12345678, 1'b1, 1'b0);
        step(12'hF01, 32'h0, 1'b0, 1'b0);
        check("stat_one", cpu_q, 32'h0000_0100);
        step(12'h010, 32'h0, 1'b0, 1'b1);
        step(12'h010, 32'h0, 1'b0, 1'b1);

        // Fill past depth, then inspect status
        for (int i = 1; i <= 9; i++) step(12'hF00, 32'(i), 1'b1, 1'b0);
        step(12'hF01, 32'h0, 1'b0, 1'b0);
`ifdef MMIO_OVF_FLAG_EN
        check("stat_full", cpu_q, 32'h0000_0806);
        step(12'hF01, 32'h0, 1'b1, 1'b0);
        step(12'hF01, 32'h0, 1'b0, 1'b0);
`endif
        check("stat_full2", cpu_q, 32'h0000_0802);

        // Push while full with a pop in the same cycle
        step(12'hF00, 32'hA5, 1'b1, 1'b1);
        step(12'hF01, 32'h0, 1'b0, 1'b0);
        check("stat_pushpop", cpu_q, 32'h0000_0802);
        for (int i = 0; i < 10; i++) step(12'h020, 32'h0, 1'b0, 1'b1);

        // Counter write and wrap
        step(12'hF02, 32'hFFFFFFFE, 1'b1, 1'b0);
        step(12'hF02, 32'h0, 1'b0, 1'b0);
        check("cnt_load", cpu_q, 32'hFFFFFFFE);
        step(12'hF02, 32'h0, 1'b0, 1'b0);
        check("cnt_inc", cpu_q, 32'hFFFFFFFF);
        step(12'hF02, 32'h0, 1'b0, 1'b0);
        check("cnt_wrap", cpu_q, 32'h0);

        // Unmapped region
        step(12'hFFF, 32'h11, 1'b1, 1'b0);
        step(12'hF03, 32'h0, 1'b0, 1'b0);
        check("unmapped", cpu_q, 32'h0);

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1: a = 12'($urandom_range(0, 15));
                2, 3: a = 12'hF00;
                4:    a = 12'hF01;
                5:    a = 12'hF02;
                default: a = 12'hF03 + 12'($urandom_range(0, 252));
            endcase
            d = $urandom;
            step(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        // Async reset while draining five entries
        for (int i = 0; i < 6; i++) step(12'h020, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(12'hF00, 32'h100 + 32'(i), 1'b1, 1'b0);
        @(negedge clock);
        cpu_address = 12'h020;
        cpu_wren    = 1'b0;
        out_ready   = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", {31'h0, out_valid}, 32'h0);
        check("async_out_data", out_data, 32'h0);
        check("async_cpu_q", cpu_q, mem_q);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(12'hF02, 32'h0, 1'b0, 1'b0);
        check("cnt_after_rst", cpu_q, 32'h0);
        step(12'hF01, 32'h0, 1'b0, 1'b0);
        check("stat_after_rst", cpu_q, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
Sits between the processor's data-memory port and the dmem syncram, downstream of the processor and upstream of dmem. Word addresses below MMIO_BASE pass straight through to dmem. The top of the 12-bit address space is decoded into three memory-mapped registers:
- an output FIFO drained by a valid/ready consumer (LED/UART driver),
- a FIFO status word,
- a free-running 32-bit cycle counter.

The block runs on the dmem clock. MMIO reads have the same one-cycle latency as a dmem read.

Parameters:
MMIO_BASE, 12'hF00, first MMIO word address; addresses >= MMIO_BASE never reach dmem
FIFO_DEPTH, 8, output FIFO entries; power of two, 2..128
CNT_W, 4, FIFO level width = log2(FIFO_DEPTH)+1

Ports:
clock  input  1  dmem clock; all state updates on rising edge
reset  input  1  asynchronous, active-high
cpu_address  input  12  word address from processor
cpu_data  input  32  store data from processor
cpu_wren  input  1  store enable from processor
cpu_q  output  32  load data to processor
mem_address  output  12  to dmem address
mem_data  output  32  to dmem data
mem_wren  output  1  to dmem wren
mem_q  input  32  from dmem q
out_data  output  32  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle

Behaviour:
- Decode:
  - dmem = cpu_address < MMIO_BASE
  - OUT = MMIO_BASE+0
  - STAT = MMIO_BASE+1
  - CNT = MMIO_BASE+2
  - MMIO_BASE+3..12'hFFF: unmapped; reads return 0, writes ignored.
- Pass-through (combinational):
  - mem_address = cpu_address.
  - mem_data = cpu_data.
  - mem_wren = cpu_wren & dmem.
  - No dmem write is ever issued for an MMIO address.
- Read return:
  - Each edge registers sel_q = !dmem and rdata_q = the MMIO value of the addressed register.
  - cpu_q = sel_q ? rdata_q : mem_q.
  - MMIO and dmem loads therefore both appear one clock after the address.
- OUT register:
  - A write pushes cpu_data into the FIFO.
  - A read returns 0; reads never pop.
- Push acceptance:
  - A push is accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and the FIFO is unchanged.
- Pop: occurs when out_valid & out_ready.
- Level:
  - Push only: +1. Pop only: -1. Both: unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FIFO outputs:
  - out_valid = (level != 0).
  - out_data = storage[rd_ptr] while valid, 32'h0 while empty.
  - A push into an empty FIFO raises out_valid on the next edge; there is no fall-through in the same cycle.
- out_valid and out_data hold stable until a pop is accepted.
- STAT read value:
  - bit0 = empty, bit1 = full.
  - bit2 = overflow (feature only, else 0).
  - bits[15:8] = level, zero-extended.
  - All other bits 0.
- CNT register:
  - Increments by 1 every clock, wrapping 32'hFFFFFFFF -> 0.
  - A write loads cpu_data; the write has priority over the increment that cycle.
  - A read returns the value before that edge's update.
- Reset (asynchronous, any time):
  - Pointers, level, counter, sel_q, rdata_q all go to 0; overflow flag goes to 0.
  - out_valid = 0, out_data = 0, cpu_q follows mem_q.
  - Entries in flight are discarded; FIFO storage contents are don't-care.

Optional Feature:
MMIO_OVF_FLAG_EN
- Defined:
  - A dropped push sets a sticky overflow flag, visible as STAT bit2.
  - Any write to STAT clears the flag.
  - If a clear and a dropped push occur in the same cycle, set wins.
- Undefined: no flag register; STAT bit2 reads 0; STAT writes are ignored.

Test Plan:
- dmem path: store 32'hDEADBEEF to 12'h010, then load 12'h010 -> mem_wren=1 on the store only; cpu_q=32'hDEADBEEF one clock after the load address.
- MMIO isolation: store to 12'hF00 -> mem_wren=0. With out_ready=0, out_valid rises on the next edge with out_data equal to the stored word; STAT reads bits[15:8]=1, bit0=0.
- Fill/overflow: 9 pushes 1..9, out_ready=0, FIFO_DEPTH=8 -> STAT full=1, level=8. Then drain with out_ready=1 -> out_data sequence 1..8 and word 9 is lost. With MMIO_OVF_FLAG_EN, STAT bit2=1 until a write to STAT clears it.
- Simultaneous push and pop when full: push 32'hA5 while out_ready=1 -> level stays 8 and 32'hA5 emerges last.
- Counter: write 32'hFFFFFFFE to 12'hF02, then read on the following cycles -> FFFFFFFE, FFFFFFFF, 0 (wrap); write priority over increment confirmed.
- Async reset asserted mid-drain with 5 entries queued -> out_valid=0 immediately without a clock edge; level=0 and counter=0 after release.
